// File: rtl/io_port.sv
// rtl/io_port.sv - FIFO-buffered bus-to-pins output port, lane serialiser with stretched trigger
// Optional key receive path enabled by defining IO_PORT_RX_EN.
module io_port #(
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_WIDTH     = 8,
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_en,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  full,
  output logic                  overflow,
  output logic                  busy,
  output logic [OUT_WIDTH-1:0]  out,
  output logic                  trigger
`ifdef IO_PORT_RX_EN
  ,
  input  logic [OUT_WIDTH-1:0]  rx_in,
  input  logic                  out_en,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_valid
`endif
);

  localparam int LANES  = DATA_WIDTH / OUT_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int STB_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int PAT_W  = 2 * ((OUT_WIDTH + 1) / 2);

  localparam logic [PAT_W-1:0]      PAT_WIDE     = {((OUT_WIDTH + 1) / 2){2'b01}};
  localparam logic [OUT_WIDTH-1:0]  IDLE_PATTERN = PAT_WIDE[OUT_WIDTH-1:0];
  localparam logic [CNT_W-1:0]      DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0]     LAST_LANE    = LANE_W'(LANES - 1);
  localparam logic [STB_W-1:0]      LAST_STB     = STB_W'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, STROBE, HOLD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [LANE_W-1:0]     lane;
  logic [STB_W-1:0]      stb_cnt;
  logic                  wr_accept;
  logic                  pop;

  // Admission looks at the registered count only, so a same-cycle pop never frees a slot early.
  assign wr_accept = in_en && (count != DEPTH_C);
  assign pop       = (state == IDLE) && (count != '0);

  always_comb begin
    count_next = count;
    if (wr_accept && !pop) begin
      count_next = count + 1'b1;
    end else if (!wr_accept && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      if (in_en && !wr_accept) begin
        overflow <= 1'b1;
      end
      busy <= (count != '0) || (state != IDLE);
    end
  end

  // The shift register holds the lanes not yet driven; out is loaded from its top lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      out     <= IDLE_PATTERN;
      trigger <= 1'b0;
      shreg   <= '0;
      lane    <= '0;
      stb_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out   <= mem[rd_ptr][DATA_WIDTH-1 -: OUT_WIDTH];
            shreg <= mem[rd_ptr] << OUT_WIDTH;
            lane  <= '0;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          trigger <= 1'b1;
          stb_cnt <= '0;
          state   <= STROBE;
        end
        STROBE: begin
          if (stb_cnt == LAST_STB) begin
            trigger <= 1'b0;
            state   <= HOLD;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (lane != LAST_LANE) begin
            lane  <= lane + 1'b1;
            out   <= shreg[DATA_WIDTH-1 -: OUT_WIDTH];
            shreg <= shreg << OUT_WIDTH;
            state <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IO_PORT_RX_EN
  logic [OUT_WIDTH-1:0] rx_meta;
  logic [OUT_WIDTH-1:0] rx_sync;
  logic [OUT_WIDTH-1:0] last_key;
  logic                 new_key;

  assign new_key = (rx_sync != '0) && (rx_sync != last_key);
  assign rx_out  = out_en ? DATA_WIDTH'(last_key) : '0;

  // A fresh key outranks a same-cycle read so it is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= '0;
      rx_sync  <= '0;
      last_key <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      if (new_key) begin
        last_key <= rx_sync;
        rx_valid <= 1'b1;
      end else if (out_en) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - self-checking bench for io_port: vector table, corner sequences, random vs model
// RX sequences are included when IO_PORT_RX_EN is defined.
module tb_io_port;

  localparam int DW       = 16;
  localparam int OW       = 8;
  localparam int DEPTH    = 8;
  localparam int S        = 2;
  localparam int LANES    = DW / OW;
  localparam int PER_LANE = S + 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          in_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          full;
  logic          overflow;
  logic          busy;
  logic          trigger;
  logic [OW-1:0] out;
`ifdef IO_PORT_RX_EN
  logic [OW-1:0] rx_in  = '0;
  logic          out_en = 1'b0;
  logic [DW-1:0] rx_out;
  logic          rx_valid;
`endif

  always #5 clk = ~clk;

  io_port #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .STROBE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in(din),
    .full(full), .overflow(overflow), .busy(busy), .out(out), .trigger(trigger)
`ifdef IO_PORT_RX_EN
    , .rx_in(rx_in), .out_en(out_en), .rx_out(rx_out), .rx_valid(rx_valid)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of words and a word-relative cycle index.
  logic [DW-1:0] m_q[$];
  bit            m_active = 1'b0;
  int            m_t      = 0;
  logic [DW-1:0] m_cur    = '0;
  logic [OW-1:0] m_out    = 8'h55;
  bit            m_trig   = 1'b0;
  bit            m_busy   = 1'b0;
  bit            m_full   = 1'b0;
  bit            m_ovf    = 1'b0;

  logic [OW-1:0] cap[$];
  bit            prev_trig = 1'b0;

  typedef struct {
    logic          r;
    logic          en;
    logic [DW-1:0] d;
    logic [OW-1:0] e_out;
    logic          e_trig;
    logic          e_busy;
    logic          e_full;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[13];
  int   rates[4] = '{10, 40, 80, 100};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [DW-1:0] d);
    int pc;
    int lane;
    int ph;
    if (!r) begin
      m_q.delete();
      m_active = 1'b0;
      m_out    = 8'h55;
      m_trig   = 1'b0;
      m_busy   = 1'b0;
      m_full   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      pc     = m_q.size();
      m_busy = (pc != 0) || m_active;
      if (en && pc == DEPTH) m_ovf = 1'b1;
      if (m_active) begin
        m_t++;
        if (m_t == LANES * PER_LANE) m_active = 1'b0;
      end else if (pc > 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (en && pc < DEPTH) m_q.push_back(d);
      m_trig = 1'b0;
      if (m_active) begin
        lane   = m_t / PER_LANE;
        ph     = m_t % PER_LANE;
        m_out  = OW'(m_cur >> ((LANES - 1 - lane) * OW));
        m_trig = (ph >= 1) && (ph <= S);
      end
      m_full = (m_q.size() == DEPTH);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic [DW-1:0] d);
    rst   = r;
    in_en = en;
    din   = d;
    @(posedge clk);
    model_edge(r, en, d);
    #1;
    check("model", {out, trigger, busy, full, overflow}, {m_out, m_trig, m_busy, m_full, m_ovf});
    if (trigger && !prev_trig) cap.push_back(out);
    prev_trig = trigger;
  endtask

  initial begin
    // reset twice, then one word 0xA5C3 traced through both lanes until busy drops
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'hA5C3, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].r, tbl[i].en, tbl[i].d);
      check($sformatf("tbl%0d", i), {out, trigger, busy, full, overflow},
            {tbl[i].e_out, tbl[i].e_trig, tbl[i].e_busy, tbl[i].e_full, tbl[i].e_ovf});
    end

    // Fill while the first word is being serialised: 9th extra write is dropped.
    cycle(1'b0, 1'b0, '0);
    cap.delete();
    cycle(1'b1, 1'b1, 16'h1000);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 1'b1, DW'(16'h1000 + i));
      if (i == 7) check("full_at_7", full, 1'b0);
      if (i == 8) check("full_at_8", full, 1'b1);
      if (i == 8) check("ovf_at_8", overflow, 1'b0);
      if (i == 9) check("ovf_at_9", overflow, 1'b1);
    end
    for (int k = 0; k < 200 && busy; k++) cycle(1'b1, 1'b0, '0);
    check("drain_busy", busy, 1'b0);
    check("drain_lanes", cap.size(), 18);
    for (int w = 0; w < 9; w++) begin
      if (2 * w + 1 < cap.size())
        check($sformatf("order%0d", w), {cap[2*w], cap[2*w+1]}, DW'(16'h1000 + w));
    end
    check("ovf_sticky", overflow, 1'b1);

    // Reset during a strobe with three words queued.
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(16'h2000 + i));
    for (int k = 0; k < 20 && !trigger; k++) cycle(1'b1, 1'b0, '0);
    check("strobe_reached", trigger, 1'b1);
    cycle(1'b0, 1'b0, '0);
    check("rst_mid_out", out, 8'h55);
    check("rst_mid_trig", trigger, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    cap.delete();
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, '0);
    check("rst_no_output", cap.size(), 0);
    check("rst_idle_out", out, 8'h55);

`ifdef IO_PORT_RX_EN
    cycle(1'b0, 1'b0, '0);
    rx_in = 8'h41;
    cycle(1'b1, 1'b0, '0);
    check("rx_lat1", rx_valid, 1'b0);
    cycle(1'b1, 1'b0, '0);
    check("rx_lat2", rx_valid, 1'b0);
    cycle(1'b1, 1'b0, '0);
    check("rx_lat3", rx_valid, 1'b1);
    check("rx_out_idle", rx_out, 16'h0000);
    out_en = 1'b1;
    #1;
    check("rx_read41", rx_out, 16'h0041);
    cycle(1'b1, 1'b0, '0);
    out_en = 1'b0;
    check("rx_cleared", rx_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, '0);
      check("rx_hold", rx_valid, 1'b0);
    end
    rx_in = 8'h42;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    out_en = 1'b1;
    #1;
    check("rx_race_read", rx_out, 16'h0041);
    cycle(1'b1, 1'b0, '0);
    out_en = 1'b0;
    check("rx_race_valid", rx_valid, 1'b1);
    out_en = 1'b1;
    #1;
    check("rx_read42", rx_out, 16'h0042);
    cycle(1'b1, 1'b0, '0);
    out_en = 1'b0;
    check("rx_cleared2", rx_valid, 1'b0);
`endif

    // Random traffic at varying write densities with occasional resets.
    cycle(1'b0, 1'b0, '0);
    for (int c = 0; c < 1600; c++) begin
      cycle(($urandom_range(0, 399) != 0), ($urandom_range(0, 99) < rates[(c / 100) % 4]),
            DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
